// File: rtl/alu_serial_rx.sv
// alu_serial_rx: serial front end of the ALU.
// Each 11-bit packet on sin is: start(0), type, d[7:0] MSB first, stop(1).
// A frame is 8 DATA packets (B then A, MSB byte first) followed by one CTL
// packet carrying {0, op[2:0], crc4[3:0]}. Framing, packet order, CRC4 and
// opcode are checked, and one result strobe is produced per frame.
module alu_serial_rx #(
    parameter int CRC_EN      = 1,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  op,
    output logic [2:0]  err_flags
);

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TYPE,
        S_BIT,
        S_STOP
    } state_t;

    state_t           state;
    logic [2:0]       bit_idx;
    logic             pkt_type;     // 0 = DATA, 1 = CTL
    logic [3:0]       pkt_cnt;      // DATA packets accepted in this frame
    logic [63:0]      data_sh;      // {B, A} once 8 DATA packets are in
    logic [6:0]       ctl_sh;       // low 7 bits of the CTL byte
    logic [3:0]       crc;          // running CRC4 of {B, A, 1, op}
    logic [TMO_W-1:0] tmo_cnt;

    logic [2:0]       ctl_op;
    logic [3:0]       crc_rx;
    logic             crc_bad;
    logic             op_bad;

    // One serial CRC4 step, polynomial x^4 + x + 1, message MSB first.
    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = c[3] ^ b;
        return {c[2], c[1], c[0] ^ fb, fb};
    endfunction

    // Legal opcodes are 000, 001, 100 and 101, i.e. exactly those with op[1] clear.
    function automatic logic op_is_legal(input logic [2:0] o);
        return (o[1] == 1'b0);
    endfunction

    assign ctl_op  = ctl_sh[6:4];
    assign crc_rx  = ctl_sh[3:0];
    assign crc_bad = (CRC_EN != 0) && (crc_rx != crc);
    assign op_bad  = !op_is_legal(ctl_op);

    // Bit FSM, packet sequencing, CRC accumulation, timeout and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_idx   <= 3'd0;
            pkt_type  <= 1'b0;
            pkt_cnt   <= 4'd0;
            data_sh   <= 64'd0;
            ctl_sh    <= 7'd0;
            crc       <= 4'd0;
            tmo_cnt   <= '0;
            out_valid <= 1'b0;
            A         <= 32'd0;
            B         <= 32'd0;
            op        <= 3'd0;
            err_flags <= 3'd0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!sin) begin
                        state   <= S_TYPE;
                        tmo_cnt <= '0;
                    end else if ((TIMEOUT_CYC > 0) && (pkt_cnt != 4'd0)) begin
                        // Line idle in the middle of a frame: abort once the budget runs out.
                        if (tmo_cnt == TMO_LAST) begin
                            out_valid <= 1'b1;
                            err_flags <= 3'b100;
                            pkt_cnt   <= 4'd0;
                            crc       <= 4'd0;
                            tmo_cnt   <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end else begin
                        tmo_cnt <= '0;
                    end
                end

                S_TYPE: begin
                    pkt_type <= sin;
                    bit_idx  <= 3'd7;
                    state    <= S_BIT;
                end

                S_BIT: begin
                    if (!pkt_type) begin
                        data_sh <= {data_sh[62:0], sin};
                        crc     <= crc4_step(crc, sin);
                    end else begin
                        ctl_sh <= {ctl_sh[5:0], sin};
                        // The CRC covers a constant 1 in place of ctl[7], then op; not the crc field.
                        if (bit_idx == 3'd7) begin
                            crc <= crc4_step(crc, 1'b1);
                        end else if (bit_idx >= 3'd4) begin
                            crc <= crc4_step(crc, sin);
                        end
                    end
                    bit_idx <= bit_idx - 3'd1;
                    if (bit_idx == 3'd0) begin
                        state <= S_STOP;
                    end
                end

                S_STOP: begin
                    state <= S_IDLE;
                    if (!sin || (!pkt_type && (pkt_cnt == 4'd8)) || (pkt_type && (pkt_cnt != 4'd8))) begin
                        // Bad stop bit or packet out of order: frame ends with ERR_DATA only.
                        out_valid <= 1'b1;
                        err_flags <= 3'b100;
                        pkt_cnt   <= 4'd0;
                        crc       <= 4'd0;
                    end else if (!pkt_type) begin
                        pkt_cnt <= pkt_cnt + 4'd1;
                    end else begin
                        out_valid <= 1'b1;
                        err_flags <= {1'b0, crc_bad, op_bad};
                        pkt_cnt   <= 4'd0;
                        crc       <= 4'd0;
                        if (!crc_bad && !op_bad) begin
                            B  <= data_sh[63:32];
                            A  <= data_sh[31:0];
                            op <= ctl_op;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Testbench for alu_serial_rx: directed frames plus random back-to-back
// frames, checked by a queue-based scoreboard and an independent monitor.
module tb_alu_serial_rx;

    logic        clk;
    logic        rst_n;
    logic        sin;
    logic        out_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  op;
    logic [2:0]  err_flags;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  flags;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    // Last values delivered by a clean frame.
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_op;

    alu_serial_rx #(
        .CRC_EN      (1),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .out_valid (out_valid),
        .A         (A),
        .B         (B),
        .op        (op),
        .err_flags (err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Remainder of (w * x^4) mod (x^4 + x + 1) by long division.
    function automatic logic [3:0] crc4_ref(input logic [67:0] w);
        logic [71:0] r;
        r = {w, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid actual=1 required=0 (cyc=%0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                    chk("err_flags", {29'd0, err_flags}, {29'd0, e.flags});
                    chk("A", A, e.a);
                    chk("B", B, e.b);
                    chk("op", {29'd0, op}, {29'd0, e.op});
                end
            end
        end
    endtask

    // Expectation for an event 'delay' cycles after now.
    task automatic push_exp(input logic [2:0] flags, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] o, input int delay);
        exp_t e;
        if (flags == 3'b000) begin
            m_a  = a;
            m_b  = b;
            m_op = o;
        end
        e.a = m_a; e.b = m_b; e.op = m_op; e.flags = flags; e.cyc = cyc + delay;
        exp_q.push_back(e);
    endtask

    task automatic send_pkt(input logic typ, input logic [7:0] d, input logic stp);
        logic [10:0] w;
        w = {1'b0, typ, d, stp};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            sin = w[i];
        end
    endtask

    // Full frame; the ending CTL stop bit is sampled 12 negedges from now.
    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                              input logic [3:0] crc, input logic [2:0] flags);
        logic [63:0] d;
        d = {b, a};
        for (int i = 0; i < 8; i++) send_pkt(1'b0, d[63 - 8*i -: 8], 1'b1);
        push_exp(flags, a, b, o, 12);
        send_pkt(1'b1, {1'b0, o, crc}, 1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_A"}, A, 32'd0);
        chk({tag, "_B"}, B, 32'd0);
        chk({tag, "_op"}, {29'd0, op}, 32'd0);
        chk({tag, "_err_flags"}, {29'd0, err_flags}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  ro;
        logic [3:0]  rc;
        logic [2:0]  rf;
        int          wait_cnt;

        m_a = 32'd0; m_b = 32'd0; m_op = 3'd0;
        rst_n = 1'b0;
        sin   = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        fork
            monitor_loop();
        join_none

        // Clean ADD frame: CRC4 of {B=2, A=1, 1, 100} is 4'hC.
        send_frame(32'h0000_0001, 32'h0000_0002, 3'b100, 4'hC, 3'b000);
        // Same frame with crc bit0 inverted.
        send_frame(32'h0000_0001, 32'h0000_0002, 3'b100, 4'hD, 3'b010);

        // Seven DATA packets then CTL: order error at the CTL stop bit.
        for (int i = 0; i < 7; i++) send_pkt(1'b0, 8'hA5 + 8'(i), 1'b1);
        push_exp(3'b100, 32'd0, 32'd0, 3'd0, 12);
        send_pkt(1'b1, {1'b0, 3'b100, 4'hC}, 1'b1);
        // Clean AND frame right after: CRC4 of {2, 1, 1, 000} is 4'h0.
        send_frame(32'h0000_0001, 32'h0000_0002, 3'b000, 4'h0, 3'b000);

        // Illegal opcode 111: CRC4 of {2, 1, 1, 111} is 4'h9.
        send_frame(32'h0000_0001, 32'h0000_0002, 3'b111, 4'h9, 3'b001);
        send_frame(32'h0000_0001, 32'h0000_0002, 3'b111, 4'h8, 3'b011);

        // Reset after packet 4 discards the partial frame.
        for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'h3C, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midframe_reset");
        m_a = 32'd0; m_b = 32'd0; m_op = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(32'h0000_0001, 32'h0000_0002, 3'b100, 4'hC, 3'b000);

        // Ninth DATA packet where CTL is due.
        for (int i = 0; i < 8; i++) send_pkt(1'b0, 8'h11 * 8'(i), 1'b1);
        push_exp(3'b100, 32'd0, 32'd0, 3'd0, 12);
        send_pkt(1'b0, 8'h77, 1'b1);

        // Stop bit sampled low.
        push_exp(3'b100, 32'd0, 32'd0, 3'd0, 12);
        send_pkt(1'b0, 8'h5A, 1'b0);
        @(negedge clk);
        sin = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(32'hDEAD_BEEF, 32'h0123_4567, 3'b101,
                   crc4_ref({32'h0123_4567, 32'hDEAD_BEEF, 1'b1, 3'b101}), 3'b000);

        // Three DATA packets then idle: abort after 20 idle-high samples.
        for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'hC3, 1'b1);
        push_exp(3'b100, 32'd0, 32'd0, 3'd0, 21);
        repeat (25) @(negedge clk);

        // Random back-to-back frames against the CRC4/opcode model.
        for (int n = 0; n < 50; n++) begin
            ra = $urandom;
            rb = $urandom;
            ro = 3'($urandom_range(0, 7));
            rc = crc4_ref({rb, ra, 1'b1, ro});
            if ($urandom_range(0, 3) == 0) rc = rc ^ 4'($urandom_range(1, 15));
            rf = {1'b0, rc != crc4_ref({rb, ra, 1'b1, ro}), !(ro inside {3'b000, 3'b001, 3'b100, 3'b101})};
            send_frame(ra, rb, ro, rc, rf);
        end

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_results actual=%0d required=0", exp_q.size());
        end
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
